// File: rtl/trig_frame_rx_pkg.sv
// Shared definitions for the triggered serial frame receiver and its upstream generator bench.
package trig_frame_pkg;
  localparam int FRAME_BITS_DEF = 14;
  localparam int TRIG_DELAY_DEF = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/trig_frame_rx_if.sv
// Frame receiver bus: upstream generator (master) drives trigger/data, receiver (slave) reports words.
interface trig_frame_rx_if
  import trig_frame_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF
);
  logic                  enable;
  logic                  trig;
  logic                  data_in;
  logic [FRAME_BITS-1:0] word;
  logic                  word_valid;
  logic                  busy;
  logic [15:0]           frame_count;
  logic                  overrun;
  logic                  parity_err;

  modport master (
    output enable, trig, data_in,
    input  word, word_valid, busy, frame_count, overrun, parity_err
  );

  modport slave (
    input  enable, trig, data_in,
    output word, word_valid, busy, frame_count, overrun, parity_err
  );
endinterface

// File: rtl/trig_edge_det.sv
// Rising-edge detector with a registered previous sample and configurable reset value.
module trig_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);
  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) r_q <= RST_VAL;
    else        r_q <= i_sig;
  end

  assign o_rise = i_sig & ~r_q;
endmodule

// File: rtl/trig_frame_rx.sv
// Triggered serial frame receiver: MSB-first capture after a programmable delay from the trigger edge.
// Build option TRIG_FRAME_PARITY_EN appends an even-parity bit after the data LSB.
module trig_frame_rx
  import trig_frame_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int TRIG_DELAY = TRIG_DELAY_DEF
) (
  input logic            clk,
  input logic            rst_n,
  trig_frame_rx_if.slave bus
);
`ifdef TRIG_FRAME_PARITY_EN
  localparam int SHIFT_LEN = FRAME_BITS + 1;
`else
  localparam int SHIFT_LEN = FRAME_BITS;
`endif
  localparam logic [7:0] DLY_LAST   = 8'(TRIG_DELAY - 1);
  localparam logic [7:0] SHIFT_LAST = 8'(SHIFT_LEN - 1);
  localparam logic [7:0] DATA_LEN   = 8'(FRAME_BITS);

  state_t                r_state;
  logic [7:0]            r_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] r_word;
  logic                  r_word_valid;
  logic [15:0]           r_frame_count;
  logic                  r_overrun;
  logic                  w_edge;
  logic [FRAME_BITS-1:0] w_shift_nxt;
`ifdef TRIG_FRAME_PARITY_EN
  logic                  r_parity_err;
`endif

  trig_edge_det #(.RST_VAL(1'b1)) u_trig_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sig  (bus.trig),
    .o_rise (w_edge)
  );

  assign w_shift_nxt = {r_shift[FRAME_BITS-2:0], bus.data_in};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_word        <= '0;
      r_word_valid  <= 1'b0;
      r_frame_count <= '0;
      r_overrun     <= 1'b0;
`ifdef TRIG_FRAME_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_word_valid <= 1'b0;
`ifdef TRIG_FRAME_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      // Any edge outside IDLE, including the DONE exit cycle, is an overrun and never starts a frame.
      if (w_edge && (r_state != ST_IDLE)) r_overrun <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_edge && bus.enable) r_state <= (TRIG_DELAY == 0) ? ST_SHIFT : ST_DELAY;
        end
        ST_DELAY: begin
          if (!bus.enable) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == DLY_LAST) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_SHIFT: begin
          if (!bus.enable) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            if (r_cnt < DATA_LEN) r_shift <= w_shift_nxt;
            if (r_cnt == SHIFT_LAST) begin
              r_state       <= ST_DONE;
              r_cnt         <= '0;
              r_word_valid  <= 1'b1;
              r_frame_count <= r_frame_count + 16'd1;
`ifdef TRIG_FRAME_PARITY_EN
              // The final cycle carries the parity bit; data is already complete in r_shift.
              r_word        <= r_shift;
              r_parity_err  <= (^r_shift) ^ bus.data_in;
`else
              r_word        <= w_shift_nxt;
`endif
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.word        = r_word;
  assign bus.word_valid  = r_word_valid;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.frame_count = r_frame_count;
  assign bus.overrun     = r_overrun;
`ifdef TRIG_FRAME_PARITY_EN
  assign bus.parity_err  = r_parity_err;
`else
  assign bus.parity_err  = 1'b0;
`endif
endmodule

// File: tb/tb_trig_frame_rx.sv
// Scoreboard bench for trig_frame_rx: one instance with TRIG_DELAY=3, one with TRIG_DELAY=0.
module tb_trig_frame_rx;
  localparam int FB = 14;
`ifdef TRIG_FRAME_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct packed {
    logic [13:0] w;
    logic        pe;
    logic [15:0] cnt;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t q0[$];
  exp_t q3[$];
  exp_t e0, e3;
  logic [15:0] m_cnt[2];
  logic [13:0] m_word[2];
  logic        m_ovr[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  trig_frame_rx_if #(.FRAME_BITS(FB)) bus0 ();
  trig_frame_rx_if #(.FRAME_BITS(FB)) bus3 ();

  trig_frame_rx #(.FRAME_BITS(FB), .TRIG_DELAY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  trig_frame_rx #(.FRAME_BITS(FB), .TRIG_DELAY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic en, input logic tr, input logic d);
    if (sel == 0) begin
      bus0.enable = en; bus0.trig = tr; bus0.data_in = d;
    end else begin
      bus3.enable = en; bus3.trig = tr; bus3.data_in = d;
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? bus0.busy : bus3.busy;
  endfunction

  // One frame: edge at offset 0, optional re-trigger offset, optional enable drop k cycles into SHIFT.
  task automatic send(input int sel, input logic [13:0] w, input logic par,
                      input int retrig, input int abort_k);
    int   d, lat;
    exp_t e;
    logic bitv;
    d   = (sel == 1) ? 3 : 0;
    lat = 1 + d + FB + PAR;
    if (abort_k < 0) begin
      m_cnt[sel]  = m_cnt[sel] + 16'd1;
      m_word[sel] = w;
      e.w   = w;
      e.pe  = (PAR == 1) ? ((^w) ^ par) : 1'b0;
      e.cnt = m_cnt[sel];
      e.cyc = 32'(cyc + lat);
      if (sel == 0) q0.push_back(e);
      else          q3.push_back(e);
    end
    if (retrig > 0) m_ovr[sel] = 1'b1;
    for (int off = 0; off <= lat; off++) begin
      bitv = 1'($urandom_range(0, 1));
      if (off >= 1 + d && off < 1 + d + FB) bitv = w[FB - 1 - (off - 1 - d)];
      else if (PAR == 1 && off == 1 + d + FB) bitv = par;
      drive(sel, !(abort_k >= 0 && off == 1 + d + abort_k), (off == 0) || (off == retrig), bitv);
      step();
      if (off == 0) chk("busy_on", 32'(busy_of(sel)), 1);
      if (abort_k >= 0 && off == 1 + d + abort_k) begin
        chk("abort_busy", 32'(busy_of(sel)), 0);
        break;
      end
    end
    drive(sel, 1'b1, 1'b0, 1'b0);
    step();
  endtask

  task automatic chk_rst();
    chk("rst_word3", 32'(bus3.word), 0);
    chk("rst_vld3",  32'(bus3.word_valid), 0);
    chk("rst_busy3", 32'(bus3.busy), 0);
    chk("rst_cnt3",  32'(bus3.frame_count), 0);
    chk("rst_ovr3",  32'(bus3.overrun), 0);
    chk("rst_perr3", 32'(bus3.parity_err), 0);
    chk("rst_word0", 32'(bus0.word), 0);
    chk("rst_busy0", 32'(bus0.busy), 0);
    chk("rst_cnt0",  32'(bus0.frame_count), 0);
    chk("rst_ovr0",  32'(bus0.overrun), 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = '0; m_word[i] = '0; m_ovr[i] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (bus3.word_valid) begin
      if (q3.size() == 0) chk("unexp_vld3", 1, 0);
      else begin
        e3 = q3.pop_front();
        chk("word3", 32'(bus3.word), 32'(e3.w));
        chk("cnt3",  32'(bus3.frame_count), 32'(e3.cnt));
        chk("perr3", 32'(bus3.parity_err), 32'(e3.pe));
        chk("vcyc3", 32'(cyc), e3.cyc);
      end
    end else if (bus3.parity_err) chk("perr_stray3", 1, 0);
  end

  always @(negedge clk) begin
    if (bus0.word_valid) begin
      if (q0.size() == 0) chk("unexp_vld0", 1, 0);
      else begin
        e0 = q0.pop_front();
        chk("word0", 32'(bus0.word), 32'(e0.w));
        chk("cnt0",  32'(bus0.frame_count), 32'(e0.cnt));
        chk("perr0", 32'(bus0.parity_err), 32'(e0.pe));
        chk("vcyc0", 32'(cyc), e0.cyc);
      end
    end else if (bus0.parity_err) chk("perr_stray0", 1, 0);
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b1, 1'b0);
    repeat (3) step();
    chk_rst();
    // Trigger held high across reset release must not look like an edge.
    rst_n = 1'b1;
    repeat (3) step();
    chk("trig_hi_busy3", 32'(bus3.busy), 0);
    chk("trig_hi_busy0", 32'(bus0.busy), 0);
    drive(0, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b0, 1'b0);
    step();

    send(1, 14'h2A5C, 1'b0, 0, -1);
    chk("single_word", 32'(bus3.word), 32'h2A5C);
    chk("single_cnt",  32'(bus3.frame_count), 1);

    send(0, 14'h3FFF, 1'b0, 0, -1);
    repeat (5) step();
    send(0, 14'h0001, 1'b0, 0, -1);
    chk("pair_word", 32'(bus0.word), 32'h0001);
    chk("pair_cnt",  32'(bus0.frame_count), 2);
    chk("pair_ovr",  32'(bus0.overrun), 0);

    send(1, 14'h1555, 1'b0, 4, -1);
    chk("retrig_ovr", 32'(bus3.overrun), 32'(m_ovr[1]));
    repeat (3) step();
    send(1, 14'h0ABC, 1'b0, 0, -1);
    chk("ovr_sticky", 32'(bus3.overrun), 1);

    send(1, 14'h3333, 1'b0, 0, 6);
    step();
    chk("abort_word", 32'(bus3.word), 32'(m_word[1]));
    chk("abort_cnt",  32'(bus3.frame_count), 32'(m_cnt[1]));

    force u_dut3.r_frame_count = 16'hFFFF;
    #1;
    release u_dut3.r_frame_count;
    m_cnt[1] = 16'hFFFF;
    chk("preset_cnt", 32'(bus3.frame_count), 32'hFFFF);
    send(1, 14'h2AAA, 1'b0, 0, -1);
    chk("wrap_cnt", 32'(bus3.frame_count), 0);

    send(0, 14'h0003, 1'b1, 0, -1);
    send(0, 14'h0003, 1'b0, 0, -1);

    // Edge landing exactly in the DONE cycle.
    send(0, 14'h1F0F, 1'b0, 1 + FB + PAR, -1);
    chk("done_edge_ovr", 32'(bus0.overrun), 1);
    repeat (3) step();
    chk("done_edge_idle", 32'(bus0.busy), 0);

    // Reset in the middle of a frame with the trigger held high throughout.
    drive(1, 1'b1, 1'b1, 1'b1);
    repeat (8) step();
    chk("midrst_busy", 32'(bus3.busy), 1);
    rst_n = 1'b0;
    repeat (3) step();
    chk_rst();
    model_reset();
    rst_n = 1'b1;
    repeat (4) step();
    chk("postrst_busy", 32'(bus3.busy), 0);
    chk("postrst_cnt",  32'(bus3.frame_count), 0);
    drive(1, 1'b1, 1'b0, 1'b0);
    step();
    send(1, 14'h1234, 1'b0, 0, -1);
    chk("postrst_word", 32'(bus3.word), 32'h1234);
    chk("postrst_ovr",  32'(bus3.overrun), 0);

    repeat (4) step();
    chk("q3_left", 32'(q3.size()), 0);
    chk("q0_left", 32'(q0.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trig_frame_rx.md
TRIG_FRAME_RX -- requirements
Module: trig_frame_rx

Interface
REQ-001 Parameter FRAME_BITS, default 14: number of data bits per serial frame, range 2..32.
REQ-002 Parameter TRIG_DELAY, default 0: clk cycles from trigger edge detection to first bit sample, range 0..255.
REQ-003 clk  input  1  system sample clock (357 MHz); all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  arms receiver; low = ignore triggers.
REQ-006 trig  input  1  frame trigger from upstream frame generator, level, synchronous to clk.
REQ-007 data_in  input  1  serial frame data from upstream generator, MSB first, synchronous to clk.
REQ-008 word  output  FRAME_BITS  last completed frame, held until next completed frame.
REQ-009 word_valid  output  1  one-cycle pulse when word updates.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 frame_count  output  16  completed frames, wraps FFFF->0000.
REQ-012 overrun  output  1  sticky: trigger edge seen while not IDLE.
REQ-013 parity_err  output  1  one-cycle pulse with word_valid on parity mismatch (see Configuration).

Function
REQ-014 Trigger edge = trig high and registered trig_q low; trig_q is reset to 1 so trig held high through reset is not an edge.
REQ-015 States IDLE, DELAY, SHIFT, DONE; IDLE->DELAY on edge with enable high and TRIG_DELAY>0, IDLE->SHIFT on edge with TRIG_DELAY=0.
REQ-016 DELAY lasts exactly TRIG_DELAY cycles then ->SHIFT; with edge in cycle E, bit k (k=0 = MSB) sampled in cycle E+1+TRIG_DELAY+k.
REQ-017 SHIFT lasts exactly FRAME_BITS cycles (plus one parity cycle when enabled) then ->DONE.
REQ-018 DONE lasts one cycle: word loaded, word_valid high, frame_count incremented, then ->IDLE.
REQ-019 Latency edge-to-word_valid = 1+TRIG_DELAY+FRAME_BITS cycles (+1 with parity).
REQ-020 Trigger edges outside IDLE are ignored for capture and set overrun; cleared only by reset.
REQ-021 enable low outside IDLE aborts to IDLE next cycle: no word_valid, word and frame_count unchanged.
REQ-022 Edge in the same cycle DONE exits is an overrun, not a new frame; next frame needs an edge while in IDLE.
REQ-023 Shift register is internal; word never shows partial frames.

Reset
REQ-024 rst_n low at a clock edge: state IDLE, word 0, word_valid 0, busy 0, frame_count 0, overrun 0, parity_err 0, trig_q 1, counters 0.
REQ-025 Reset mid-frame discards the partial frame with no word_valid.

Configuration
REQ-026 Macro TRIG_FRAME_PARITY_EN defined: one extra even-parity bit sampled after the data LSB; parity_err pulses with word_valid when XOR of data and parity bit is 1; word still updates.
REQ-027 Macro undefined: no parity cycle, parity_err tied 0, latency per REQ-019 without +1.

Structure
REQ-028 Shared package trig_frame_pkg holds the state enumeration and the FRAME_BITS/TRIG_DELAY default constants, for reuse by the upstream generator bench.
REQ-029 One sub-module, trig_edge_det (registered rising-edge detector with reset value parameter), instantiated for trig.

Verification
REQ-030 FRAME_BITS=14, TRIG_DELAY=3, enable=1, edge at cycle 10, serial 14'h2A5C -> word=14'h2A5C, word_valid only in cycle 28, frame_count=1.
REQ-031 TRIG_DELAY=0, two frames 14'h3FFF then 14'h0001 separated by 5 idle cycles -> two word_valid pulses, words in order, frame_count=2, overrun=0.
REQ-032 Second trig edge 4 cycles after first -> first frame completes correctly, overrun=1 and stays 1, frame_count=1.
REQ-033 enable dropped 6 cycles into SHIFT -> no word_valid, busy low next cycle, word unchanged; frame_count preset to 16'hFFFF wraps to 0 on next good frame.
REQ-034 trig high through reset release, rst_n low for 3 cycles mid-frame -> all outputs at reset values, no capture until trig falls and rises again.
REQ-035 TRIG_FRAME_PARITY_EN defined, data 14'h0003 with parity 1 -> parity_err pulse with word_valid; parity 0 -> no pulse.
